// File: rtl/paralelo_serial_pkg.sv
// Shared definitions for the parametrised parallel-to-serial converter:
// FSM state encoding, the default COM/IDLE symbol and a ceil-log2 helper.
package paralelo_serial_pkg;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [7:0] COM_WORD = 8'hBC;

  // Ceil(log2(value)); elaboration-time sizing of counters and pointers.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with first-word-fall-through head output.
// Push while full and pop while empty are ignored.
module fifo_sync_param
  import paralelo_serial_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PW = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH);
  localparam int CW = clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/serializador_param.sv
// Parallel-to-serial converter on the bit clock: words enter a FIFO over
// valid/ready and leave as back-to-back frames, with IDLE inserted when starved.
module serializador_param
  import paralelo_serial_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(COM_WORD),
  parameter bit                    MSB_FIRST  = 1'b1,
  parameter int                    FIFO_DEPTH = 4,
  parameter int                    SYNC_WORDS = 2
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  word_start,
  output logic                  sending_idle,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  state_dbg
);

  // Handshake: a word moves into the FIFO on every rising edge where
  // valid_in && ready_out; the sender holds data_in/valid_in until then.

  localparam int BW = clog2(DATA_WIDTH);
  localparam int SW = clog2(SYNC_WORDS) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_WORDS - 1);

  state_e                state_q;
  logic [SW-1:0]         sync_cnt_q;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, word_d, fifo_head;
  logic                  data_q, word_start_q, sending_idle_q;
  logic                  load, use_idle, push, pop, out_bit_d;

  assign load      = (bit_cnt_q == LAST_BIT);
  assign use_idle  = (state_q == ST_SYNC) || fifo_empty;
  assign pop       = load && !use_idle;
  assign push      = valid_in && !fifo_full;
  assign ready_out = !fifo_full;

  assign data_out     = data_q;
  assign word_start   = word_start_q;
  assign sending_idle = sending_idle_q;
  assign state_dbg    = state_q;

  fifo_sync_param #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_32f),
    .rst_i  (reset),
    .push_i (push),
    .din_i  (data_in),
    .pop_i  (pop),
    .dout_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // On a load edge the first bit goes straight out and the rest is parked in
  // the shift register, so the frame occupies exactly DATA_WIDTH edges.
  always_comb begin
    bit_cnt_d = load ? '0 : bit_cnt_q + BW'(1);
    word_d    = use_idle ? IDLE_WORD : fifo_head;
    if (MSB_FIRST) begin
      out_bit_d = load ? word_d[DATA_WIDTH-1] : shift_q[DATA_WIDTH-1];
      shift_d   = load ? (word_d << 1) : (shift_q << 1);
    end else begin
      out_bit_d = load ? word_d[0] : shift_q[0];
      shift_d   = load ? (word_d >> 1) : (shift_q >> 1);
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SYNC;
      sync_cnt_q     <= '0;
      bit_cnt_q      <= LAST_BIT;
      shift_q        <= '0;
      data_q         <= 1'b0;
      word_start_q   <= 1'b0;
      sending_idle_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= out_bit_d;
      word_start_q <= load;
      if (load) sending_idle_q <= use_idle;
      if (load && state_q == ST_SYNC) begin
        sync_cnt_q <= sync_cnt_q + SW'(1);
        if (sync_cnt_q == LAST_SYNC) state_q <= ST_ACTIVE;
      end
    end
  end

endmodule

// File: tb/tb_serializador_param.sv
// Directed bench for serializador_param: an MSB-first instance checked by a
// frame monitor plus scoreboard, and an LSB-first instance checked inline.
module tb_serializador_param;

  localparam int DW = 8;
  localparam logic [DW-1:0] IDLE = 8'hBC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          valid1, valid2;
  logic [DW-1:0] data1, data2;
  logic ready1, dout1, ws1, si1, full1, empty1, st1;
  logic ready2, dout2, ws2, si2, full2, empty2, st2;

  serializador_param dut (
    .clk_32f(clk), .reset(reset), .valid_in(valid1), .data_in(data1),
    .ready_out(ready1), .data_out(dout1), .word_start(ws1), .sending_idle(si1),
    .fifo_full(full1), .fifo_empty(empty1), .state_dbg(st1)
  );

  serializador_param #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk_32f(clk), .reset(reset), .valid_in(valid2), .data_in(data2),
    .ready_out(ready2), .data_out(dout2), .word_start(ws2), .sending_idle(si2),
    .fifo_full(full2), .fifo_empty(empty2), .state_dbg(st2)
  );

  int edge_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] frame_word[$];
  logic          frame_idle[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor for the MSB-first instance.
  logic [DW-1:0] cur;
  int            nbits = 0;
  logic          cur_idle, in_frame = 1'b0, need_start = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      in_frame   = 1'b0;
      need_start = 1'b0;
      nbits      = 0;
      frame_word.delete();
      frame_idle.delete();
    end else if (ws1) begin
      if (in_frame) check("frame_len", nbits, DW);
      cur        = {{(DW-1){1'b0}}, dout1};
      nbits      = 1;
      cur_idle   = si1;
      in_frame   = 1'b1;
      need_start = 1'b0;
    end else if (in_frame) begin
      cur = {cur[DW-2:0], dout1};
      nbits++;
      check("idle_hold", si1, cur_idle);
    end else if (need_start) begin
      check("no_gap", ws1, 1);
      need_start = 1'b0;
    end
    if (!reset && in_frame && nbits == DW) begin
      frame_word.push_back(cur);
      frame_idle.push_back(cur_idle);
      in_frame   = 1'b0;
      need_start = 1'b1;
      if (cur_idle) begin
        check("idle_word", cur, IDLE);
      end else begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("sb_word", cur, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [DW-1:0] w);
    int n;
    logic rdy;
    n = 0;
    valid1 = 1'b1;
    data1  = w;
    rdy    = ready1;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = ready1;
      n++;
    end
    check("send_ready", rdy, 1);
    @(posedge clk);
    exp_q.push_back(w);
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frame_word.size() < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("wait_frames", frame_word.size() >= n, 1);
  endtask

  // Captures one LSB-instance frame in transmit order (first bit in bit 7).
  task automatic capture2(output logic [DW-1:0] bits, output logic idl);
    int k;
    k = 0;
    while (!ws2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("lsb_word_start", ws2, 1);
    bits = '0;
    idl  = si2;
    for (int i = 0; i < DW; i++) begin
      bits = {bits[DW-2:0], dout2};
      if (i < DW - 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] bits;
    logic          idl;
    logic          saw_nonempty;
    int            k;

    reset  = 1'b1;
    valid1 = 1'b0; data1 = '0;
    valid2 = 1'b0; data2 = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_data_out", dout1, 0);
    check("rst_word_start", ws1, 0);
    check("rst_sending_idle", si1, 0);
    check("rst_fifo_empty", empty1, 1);
    check("rst_fifo_full", full1, 0);
    check("rst_ready", ready1, 1);
    check("rst_state", st1, 0);
    check("rst_lsb_data_out", dout2, 0);

    // Idle stream after reset
    reset = 1'b0;
    @(negedge clk);
    check("t1_first_ws", ws1, 1);
    check("t1_first_bit", dout1, 1);
    check("t1_first_idle", si1, 1);
    saw_nonempty = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (!empty1) saw_nonempty = 1'b1;
    end
    check("t1_fifo_empty", saw_nonempty, 0);
    wait_frames(3);
    for (int i = 0; i < 3; i++) check("t1_idle_frame", frame_idle[i], 1);

    // Writes during SYNC appear after exactly SYNC_WORDS idle frames
    do_reset();
    send(8'hFF);
    send(8'hEE);
    wait_frames(5);
    check("t2_f0_idle", frame_idle[0], 1);
    check("t2_f1_idle", frame_idle[1], 1);
    check("t2_f2_data", frame_idle[2], 0);
    check("t2_f2_word", frame_word[2], 8'hFF);
    check("t2_f3_data", frame_idle[3], 0);
    check("t2_f3_word", frame_word[3], 8'hEE);
    check("t2_f4_idle", frame_idle[4], 1);
    check("t2_fifo_empty", empty1, 1);
    check("t2_state_active", st1, 1);

    // Fill the FIFO, back-pressure, then drain without gaps
    do_reset();
    for (int i = 1; i <= 4; i++) send(DW'(i));
    check("t3_xfer4_edge", edge_cnt, 4);
    check("t3_full", full1, 1);
    check("t3_ready_low", ready1, 0);
    send(8'h05);
    check("t3_xfer5_edge", edge_cnt, 18);
    wait_frames(8);
    for (int i = 2; i <= 6; i++) begin
      check("t3_data_frame", frame_idle[i], 0);
      check("t3_data_word", frame_word[i], DW'(i - 1));
    end
    check("t3_tail_idle", frame_idle[7], 1);

    // Reset in the middle of a data frame discards everything
    do_reset();
    send(8'hFF);
    send(8'hEE);
    send(8'hDD);
    k = 0;
    while (edge_cnt < 20 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_bit3_value", dout1, 1);
    check("t5_queued", empty1, 0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t5_rst_data_out", dout1, 0);
    check("t5_rst_fifo_empty", empty1, 1);
    check("t5_rst_word_start", ws1, 0);
    check("t5_rst_ready", ready1, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_frames(4);
    for (int i = 0; i < 4; i++) check("t5_idle_frame", frame_idle[i], 1);

    // Write landing exactly on a load edge with the FIFO empty
    k = 0;
    while (!(edge_cnt >= 40 && edge_cnt % 8 == 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    k = edge_cnt / 8;
    send(8'h7F);
    check("t6_xfer_edge", edge_cnt, 8 * k + 1);
    wait_frames(k + 2);
    check("t6_load_frame_idle", frame_idle[k], 1);
    check("t6_next_frame_data", frame_idle[k + 1], 0);
    check("t6_next_frame_word", frame_word[k + 1], 8'h7F);

    // LSB-first instance
    capture2(bits, idl);
    check("t4_idle_bits", bits, 8'b00111101);
    check("t4_idle_flag", idl, 1);
    check("t4_ready", ready2, 1);
    valid2 = 1'b1;
    data2  = 8'h03;
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    k = 0;
    idl = 1'b1;
    while (idl && k < 4) begin
      capture2(bits, idl);
      k++;
    end
    check("t4_data_flag", idl, 0);
    check("t4_data_bits", bits, 8'b11000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serializador_param.md
Name: serializador_param

Overview:
- Parametrised successor to the 8-bit parallel-to-serial converter.
- Runs on the single fast bit clock `clk_32f` only; word framing comes from an internal bit counter, not from a separate `clk_4f`.
- Accepts parallel words over a valid/ready handshake into a small FIFO. Emits them as a serial bit stream, MSB- or LSB-first.
- Inserts the IDLE (COM) word whenever no data is queued, and sends a programmable number of IDLE sync words after reset before any data.

Parameters:
- DATA_WIDTH, 8, bits per parallel word and per serial frame (>=2).
- IDLE_WORD, 8'hBC, word transmitted when the FIFO is empty and during sync.
- MSB_FIRST, 1, 1 = bit DATA_WIDTH-1 sent first; 0 = bit 0 sent first.
- FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2).
- SYNC_WORDS, 2, IDLE words sent after reset before data may be drained (>=1).

Ports:
- clk_32f  in  1  bit clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  data_in holds a word to transfer.
- data_in  in  DATA_WIDTH  parallel word.
- ready_out  out  1  = !fifo_full; transfer occurs on an edge where valid_in && ready_out.
- data_out  out  1  registered serial bit.
- word_start  out  1  registered; high during the first bit of every frame.
- sending_idle  out  1  registered; high for all bits of a frame carrying IDLE_WORD inserted by the block.
- fifo_full  out  1  occupancy == FIFO_DEPTH.
- fifo_empty  out  1  occupancy == 0.

Behaviour:
- Reset (async assert, sync use on deassert):
  - data_out=0, word_start=0, sending_idle=0.
  - FIFO flushed: fifo_empty=1, fifo_full=0, ready_out=1.
  - State=SYNC, sync_cnt=0, bit_cnt=DATA_WIDTH-1 so that the first edge after reset is a load edge.
- Bit counter: increments each edge; wraps DATA_WIDTH-1 -> 0. A load edge is one where bit_cnt==DATA_WIDTH-1 before the edge.
- Load edge:
  - Select next word W: IDLE_WORD if state==SYNC or the FIFO is empty; otherwise pop the FIFO head.
  - data_out <= first bit of W; shift register <= remaining bits; word_start<=1; sending_idle<=(W was inserted IDLE).
  - The first bit therefore appears one edge after the load decision, and the frame lasts exactly DATA_WIDTH edges.
- Non-load edge: data_out <= next bit of the shift register in the MSB_FIRST order; word_start<=0; sending_idle holds.
- Data that equals IDLE_WORD and comes from the FIFO has sending_idle=0.
- FSM:
  - SYNC: each load edge increments sync_cnt. On the load edge with sync_cnt==SYNC_WORDS-1, go to ACTIVE. That edge still loads IDLE.
  - ACTIVE: stays until reset.
- FIFO:
  - Writes are accepted in both states. Popping occurs only in ACTIVE.
  - A word written on edge k is visible for a pop at earliest on edge k+1.
  - Write on empty and load on the same edge: the load sends IDLE; the word goes in the next frame.
  - Full: ready_out=0 and no write, even if a pop happens on the same edge. ready_out rises the edge after a pop.
  - Pop when empty never happens; IDLE is inserted instead.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
- Sender must hold data_in and valid_in stable until the transfer.
- Reset mid-frame: outputs go to reset values immediately. The partial frame and FIFO contents are discarded. The full SYNC sequence restarts.
- Throughput: one word per DATA_WIDTH clocks; no gaps between frames.

Decomposition:
- Shared package (paralelo_serial_pkg):
  - state encoding SYNC/ACTIVE;
  - default IDLE_WORD (8'hBC COM);
  - clog2 helper function.
- One sub-module, fifo_sync_param (DATA_WIDTH, FIFO_DEPTH): push, pop, dout head, full, empty.
- The FSM, bit counter and shift register live in the top.

Test Plan (DATA_WIDTH=8, IDLE_WORD=BC, MSB_FIRST=1, FIFO_DEPTH=4, SYNC_WORDS=2 unless stated):
1. Reset pulse, valid_in=0 -> data_out repeats 10111100, word_start every 8th clock, sending_idle=1; fifo_empty=1 throughout.
2. During SYNC, write FF then EE -> after exactly 2 BC frames: 11111111, 11101110 (sending_idle=0), then BC frames resume; fifo_empty=1 after the second pop.
3. Hold valid_in=1 with data 01,02,03,04,05 from reset -> ready_out drops after the 4th transfer, fifo_full=1. Word 05 transfers the edge after the first pop. Stream after sync is 01,02,03,04,05 with no gaps.
4. MSB_FIRST=0, write 03 in ACTIVE -> serial frame 11000000; IDLE frames are 00111101.
5. Assert reset at bit 3 of an FF frame with 2 words queued -> data_out=0 and fifo_empty=1 immediately. After release, 2 BC sync frames follow; the queued words are never sent.
6. Write 7F on the exact load edge with the FIFO empty in ACTIVE -> that frame is BC; the next frame is 01111111.
